// File: rtl/seq_frame_ctrl.sv
// Serial frame controller: hunts for a 4-bit sync pattern on a strobed bit
// stream, then captures a 1..16 bit payload and reports it with a frame count.
module seq_frame_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             en,
  input  logic [3:0]       pattern,
  input  logic [3:0]       plen,
  output logic             sync_det,
  output logic             busy,
  output logic [15:0]      data_out,
  output logic             data_valid,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned DW  = 16;
  localparam int unsigned PW  = 4;
  localparam int unsigned BCW = 5;
  localparam int unsigned FW  = 3;

  typedef enum logic {
    HUNT = 1'b0,
    CAPT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [PW-1:0]    hist, hist_n;
  logic [FW-1:0]    fill, fill_n;
  logic [BCW-1:0]   bit_cnt, bit_cnt_n;
  logic [DW-1:0]    cap, cap_n;
  logic [PW-1:0]    plen_l, plen_l_n;
  logic             sync_det_n, busy_n, data_valid_n;
  logic [DW-1:0]    data_out_n;
  logic [CNT_W-1:0] frame_cnt_n;

  logic [PW-1:0]    cand;
  logic [DW-1:0]    cap_sh;
  logic [BCW-1:0]   bit_inc;
  logic [BCW-1:0]   bit_tgt;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      hist       <= '0;
      fill       <= '0;
      bit_cnt    <= '0;
      cap        <= '0;
      plen_l     <= '0;
      sync_det   <= 1'b0;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_n;
      hist       <= hist_n;
      fill       <= fill_n;
      bit_cnt    <= bit_cnt_n;
      cap        <= cap_n;
      plen_l     <= plen_l_n;
      sync_det   <= sync_det_n;
      busy       <= busy_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      frame_cnt  <= frame_cnt_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    hist_n       = hist;
    fill_n       = fill;
    bit_cnt_n    = bit_cnt;
    cap_n        = cap;
    plen_l_n     = plen_l;
    sync_det_n   = 1'b0;
    data_valid_n = 1'b0;
    data_out_n   = data_out;
    frame_cnt_n  = frame_cnt;

    cand    = {hist[PW-2:0], x};
    cap_sh  = {cap[DW-2:0], x};
    bit_inc = bit_cnt + BCW'(1);
    // A latched length of 0 means a full 16-bit payload
    bit_tgt = (plen_l == '0) ? BCW'(16) : BCW'(plen_l);

    case (state)
      HUNT: begin
        if (en) begin
          hist_n = cand;
          if (fill != FW'(4)) fill_n = fill + FW'(1);
          // fill >= 3 here means this bit makes at least 4 valid history bits
          if ((cand == pattern) && (fill >= FW'(3))) begin
            state_n    = CAPT;
            plen_l_n   = plen;
            bit_cnt_n  = '0;
            cap_n      = '0;
            sync_det_n = 1'b1;
          end
        end
      end
      CAPT: begin
        if (en) begin
          cap_n     = cap_sh;
          bit_cnt_n = bit_inc;
          if (bit_inc == bit_tgt) begin
            data_out_n   = cap_sh;
            data_valid_n = 1'b1;
            if (frame_cnt != {CNT_W{1'b1}}) frame_cnt_n = frame_cnt + CNT_W'(1);
            state_n = HUNT;
            hist_n  = '0;
            fill_n  = '0;
          end
        end
      end
      default: state_n = HUNT;
    endcase

    busy_n = (state_n == CAPT);
  end

endmodule

// File: tb/tb_seq_frame_ctrl.sv
// Scoreboard bench for seq_frame_ctrl: expected pulses are queued as bits are
// driven and matched against DUT pulses (CNT_W=8 and a CNT_W=2 copy).
module tb_seq_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        x;
  logic        en;
  logic [3:0]  pattern;
  logic [3:0]  plen;
  logic        sync_det, busy, data_valid;
  logic [15:0] data_out;
  logic [7:0]  frame_cnt;
  logic        sync_det2, busy2, data_valid2;
  logic [15:0] data_out2;
  logic [1:0]  frame_cnt2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int          kind;   // 1 = sync_det, 2 = data_valid
    int          cyc;
    logic [15:0] d;
    int          c;
    int          c2;
  } ev_t;

  ev_t q[$];

  seq_frame_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .x(x), .en(en), .pattern(pattern), .plen(plen),
    .sync_det(sync_det), .busy(busy), .data_out(data_out),
    .data_valid(data_valid), .frame_cnt(frame_cnt)
  );

  seq_frame_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .x(x), .en(en), .pattern(pattern), .plen(plen),
    .sync_det(sync_det2), .busy(busy2), .data_out(data_out2),
    .data_valid(data_valid2), .frame_cnt(frame_cnt2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Pulse monitor, sampled just after the active edge
  always @(posedge clk) begin
    #1;
    if (!rst && (sync_det || data_valid)) begin
      if (q.size() == 0) begin
        check("extra_pulse", 32'({sync_det, data_valid}), 32'd0);
      end else begin
        ev_t e;
        e = q.pop_front();
        check("pulse_kind", data_valid ? 32'd2 : 32'd1, 32'(e.kind));
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        if (data_valid) begin
          check("data_out", 32'(data_out), 32'(e.d));
          check("frame_cnt", 32'(frame_cnt), 32'(e.c));
          check("frame_cnt_w2", 32'(frame_cnt2), 32'(e.c2));
          check("data_valid_w2", 32'(data_valid2), 32'd1);
          check("busy_at_dv", 32'(busy), 32'd0);
        end else begin
          check("busy_at_sync", 32'(busy), 32'd1);
        end
      end
    end
  end

  // Drive one bit at a negedge, optionally queueing the pulse it should cause
  task automatic send(input logic b, input int gap, input int kind,
                      input logic [15:0] d, input int c);
    ev_t e;
    if (kind != 0) begin
      e.kind = kind;
      e.cyc  = cyc + 1;
      e.d    = d;
      e.c    = c;
      e.c2   = (c > 3) ? 3 : c;
      q.push_back(e);
    end
    x  = b;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    x  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic frame(input logic [3:0] p, input logic [15:0] pay, input int n,
                       input int gap, input int c);
    for (int i = 3; i >= 0; i--) send(p[i], gap, (i == 0) ? 1 : 0, 16'h0, 0);
    for (int i = n - 1; i >= 0; i--) send(pay[i], gap, (i == 0) ? 2 : 0, pay, c);
  endtask

  task automatic do_reset();
    check("pending_events", 32'(q.size()), 32'd0);
    q.delete();
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_sync_det", 32'(sync_det), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_frame_cnt_w2", 32'(frame_cnt2), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    x       = 1'b0;
    en      = 1'b0;
    pattern = 4'b1010;
    plen    = 4'd4;
    repeat (2) @(negedge clk);
    do_reset();

    // Basic frame, second frame, then completion bit must not seed the hunt
    frame(4'b1010, 16'h000C, 4, 0, 1);
    frame(4'b1010, 16'h000D, 4, 0, 2);
    send(1'b0, 0, 0, 16'h0, 0);
    send(1'b1, 0, 0, 16'h0, 0);
    send(1'b0, 0, 0, 16'h0, 0);
    send(1'b1, 0, 0, 16'h0, 0);
    send(1'b0, 0, 1, 16'h0, 0);
    check("data_hold", 32'(data_out), 32'h000D);
    do_reset();

    // Overlapped hunt: 1,1,0,1,0 matches only on the fifth bit
    send(1'b1, 0, 0, 16'h0, 0);
    send(1'b1, 0, 0, 16'h0, 0);
    send(1'b0, 0, 0, 16'h0, 0);
    send(1'b1, 0, 0, 16'h0, 0);
    send(1'b0, 0, 1, 16'h0, 0);
    repeat (3) @(negedge clk);
    do_reset();

    // Strobe gaps of three idle cycles between bits
    frame(4'b1010, 16'h000C, 4, 3, 1);
    repeat (4) @(negedge clk);
    check("gap_data_hold", 32'(data_out), 32'h000C);
    check("gap_frame_cnt", 32'(frame_cnt), 32'd1);

    // Reset after two payload bits discards the partial frame
    frame(4'b1010, 16'h0003, 2, 0, 0);
    q.delete();
    do_reset();
    frame(4'b1010, 16'h0009, 4, 0, 1);
    do_reset();

    // 16-bit payload with pattern/plen changed mid-capture
    plen = 4'd0;
    frame(4'b1010, 16'h0000, 0, 0, 0);
    for (int i = 15; i >= 0; i--) begin
      logic [15:0] pay;
      pay = 16'hA5C3;
      if (i == 12) begin
        plen    = 4'd4;
        pattern = 4'b1111;
      end
      send(pay[i], 0, (i == 0) ? 2 : 0, 16'hA5C3, 1);
    end
    pattern = 4'b1010;
    plen    = 4'd4;
    do_reset();

    // Back-to-back frames; CNT_W=2 copy saturates at 3
    for (int k = 1; k <= 5; k++) frame(4'b1010, 16'(k), 4, 0, k);
    repeat (2) @(negedge clk);
    check("pending_final", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
